// File: rtl/stage_seq_pkg.sv
// rtl/stage_seq_pkg.sv - Stage codes and FSM state type shared by stage_sequencer.
package stage_seq_pkg;

    localparam logic [2:0] STAGE_IDLE      = 3'd0;
    localparam logic [2:0] STAGE_FETCH     = 3'd1;
    localparam logic [2:0] STAGE_DECODE    = 3'd2;
    localparam logic [2:0] STAGE_EXECUTE   = 3'd3;
    localparam logic [2:0] STAGE_MEMORY    = 3'd4;
    localparam logic [2:0] STAGE_WRITEBACK = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } seq_state_t;

endpackage

// File: rtl/stall_timer.sv
// rtl/stall_timer.sv - Memory-stall cycle counter with a timeout flag at WAIT_MAX.
module stall_timer #(
    parameter int WAIT_W   = 4,
    parameter int WAIT_MAX = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic timeout
);

    logic [WAIT_W-1:0] count;

    // Saturates so a caller that keeps incrementing past the limit never wraps back to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != WAIT_W'(WAIT_MAX))) begin
            count <= count + WAIT_W'(1);
        end
    end

    assign timeout = (count == WAIT_W'(WAIT_MAX));

endmodule

// File: rtl/stage_sequencer.sv
// rtl/stage_sequencer.sv - 5-stage sequencer FSM with memory stalls; STAGE_SEQ_PERF_EN adds perf counters.
module stage_sequencer
    import stage_seq_pkg::*;
#(
    parameter int STAGE_W  = 3,
    parameter int WAIT_W   = 4,
    parameter int WAIT_MAX = 15
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Run,
    input  logic               Step,
    input  logic               Halt_Request,
    input  logic               Mem_Ready,
    input  logic               Mem_Access_WB,
    input  logic               Opcode_Is_NOP,
    output logic [STAGE_W-1:0] Stage,
    output logic               NOP_FLAG,
    output logic               Instr_Done,
    output logic               Running,
    output logic               Halted,
`ifdef STAGE_SEQ_PERF_EN
    output logic [31:0]        Instr_Count,
    output logic [31:0]        Stall_Count,
`endif
    output logic               Mem_Timeout
);

    seq_state_t state;
    logic       step_latch;
    logic       fetch_wait;
    logic       mem_wait;
    logic       stalled;
    logic       wait_expired;

    // A NOP never touches memory in stage 4, so its registered flag suppresses that stall.
    assign fetch_wait = (Stage == STAGE_W'(STAGE_FETCH)) && !Mem_Ready;
    assign mem_wait   = (Stage == STAGE_W'(STAGE_MEMORY)) && Mem_Access_WB && !NOP_FLAG && !Mem_Ready;
    assign stalled    = (state == S_RUN) && (fetch_wait || mem_wait);

    stall_timer #(
        .WAIT_W   (WAIT_W),
        .WAIT_MAX (WAIT_MAX)
    ) u_stall_timer (
        .clk     (Clock),
        .rst     (Reset),
        .clear   (!stalled),
        .inc     (stalled),
        .timeout (wait_expired)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state       <= S_IDLE;
            Stage       <= '0;
            NOP_FLAG    <= 1'b0;
            Instr_Done  <= 1'b0;
            Running     <= 1'b0;
            Halted      <= 1'b0;
            Mem_Timeout <= 1'b0;
            step_latch  <= 1'b0;
        end else begin
            Instr_Done <= 1'b0;
            case (state)
                S_IDLE: begin
                    Stage    <= STAGE_W'(STAGE_IDLE);
                    NOP_FLAG <= 1'b0;
                    if (Halt_Request) begin
                        state   <= S_HALTED;
                        Halted  <= 1'b1;
                        Running <= 1'b0;
                    end else if (Run || Step) begin
                        state      <= S_RUN;
                        Running    <= 1'b1;
                        Stage      <= STAGE_W'(STAGE_FETCH);
                        step_latch <= !Run;
                    end
                end
                S_RUN: begin
                    if (stalled) begin
                        if (wait_expired) begin
                            state       <= S_HALTED;
                            Halted      <= 1'b1;
                            Running     <= 1'b0;
                            Mem_Timeout <= 1'b1;
                            Stage       <= STAGE_W'(STAGE_IDLE);
                            NOP_FLAG    <= 1'b0;
                            step_latch  <= 1'b0;
                        end
                    end else begin
                        case (Stage)
                            STAGE_W'(STAGE_DECODE): begin
                                NOP_FLAG <= Opcode_Is_NOP;
                                Stage    <= STAGE_W'(STAGE_EXECUTE);
                            end
                            STAGE_W'(STAGE_WRITEBACK): begin
                                Instr_Done <= 1'b1;
                                NOP_FLAG   <= 1'b0;
                                if (Halt_Request) begin
                                    state   <= S_HALTED;
                                    Halted  <= 1'b1;
                                    Running <= 1'b0;
                                    Stage   <= STAGE_W'(STAGE_IDLE);
                                end else if (step_latch || !Run) begin
                                    state      <= S_IDLE;
                                    Running    <= 1'b0;
                                    Stage      <= STAGE_W'(STAGE_IDLE);
                                    step_latch <= 1'b0;
                                end else begin
                                    Stage <= STAGE_W'(STAGE_FETCH);
                                end
                            end
                            default: begin
                                Stage <= Stage + STAGE_W'(1);
                            end
                        endcase
                    end
                end
                default: begin
                    Stage    <= STAGE_W'(STAGE_IDLE);
                    NOP_FLAG <= 1'b0;
                    Halted   <= 1'b1;
                    Running  <= 1'b0;
                end
            endcase
        end
    end

`ifdef STAGE_SEQ_PERF_EN
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Instr_Count <= '0;
            Stall_Count <= '0;
        end else begin
            if (Instr_Done) begin
                Instr_Count <= Instr_Count + 32'd1;
            end
            if (stalled) begin
                Stall_Count <= Stall_Count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_stage_sequencer.sv
// tb/tb_stage_sequencer.sv - Scoreboard bench for stage_sequencer against a cycle-level behavioural model.
module tb_stage_sequencer;

    localparam int WAIT_MAX = 15;
    localparam int M_IDLE   = 0;
    localparam int M_RUN    = 1;
    localparam int M_HALT   = 2;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       Run = 1'b0, Step = 1'b0, Halt_Request = 1'b0;
    logic       Mem_Ready = 1'b0, Mem_Access_WB = 1'b0, Opcode_Is_NOP = 1'b0;
    logic [2:0] Stage;
    logic       NOP_FLAG, Instr_Done, Running, Halted, Mem_Timeout;
`ifdef STAGE_SEQ_PERF_EN
    logic [31:0] instr_count, stall_count;
`endif

    stage_sequencer dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .Run           (Run),
        .Step          (Step),
        .Halt_Request  (Halt_Request),
        .Mem_Ready     (Mem_Ready),
        .Mem_Access_WB (Mem_Access_WB),
        .Opcode_Is_NOP (Opcode_Is_NOP),
        .Stage         (Stage),
        .NOP_FLAG      (NOP_FLAG),
        .Instr_Done    (Instr_Done),
        .Running       (Running),
        .Halted        (Halted),
`ifdef STAGE_SEQ_PERF_EN
        .Instr_Count   (instr_count),
        .Stall_Count   (stall_count),
`endif
        .Mem_Timeout   (Mem_Timeout)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic [2:0] stage;
        logic       nop;
        logic       done;
        logic       running;
        logic       halted;
        logic       timeout;
    } obs_t;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Behavioural model: which mode we are in, which stage, how long this stage has waited on memory.
    int m_mode, m_stage, m_wait;
    bit m_once, m_nop, m_done, m_to;

    function automatic obs_t model_view();
        obs_t o;
        o.stage   = 3'(m_stage);
        o.nop     = m_nop;
        o.done    = m_done;
        o.running = (m_mode == M_RUN);
        o.halted  = (m_mode == M_HALT);
        o.timeout = m_to;
        return o;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_stage = 0; m_wait = 0;
        m_once = 0; m_nop = 0; m_done = 0; m_to = 0;
    endtask

    task automatic model_clock(input bit run, input bit step, input bit halt,
                               input bit ready, input bit wb, input bit op);
        bit needs_mem;
        m_done = 0;
        if (m_mode == M_IDLE) begin
            if (halt) m_mode = M_HALT;
            else if (run || step) begin
                m_mode = M_RUN; m_stage = 1; m_once = !run;
            end
        end else if (m_mode == M_RUN) begin
            needs_mem = (m_stage == 1) || (m_stage == 4 && wb && !m_nop);
            if (needs_mem && !ready) begin
                m_wait++;
                if (m_wait > WAIT_MAX) begin
                    m_mode = M_HALT; m_stage = 0; m_nop = 0; m_to = 1;
                end
            end else begin
                m_wait = 0;
                if (m_stage == 2) m_nop = op;
                if (m_stage < 5) m_stage++;
                else begin
                    m_done = 1; m_nop = 0; m_stage = 0;
                    if (halt) m_mode = M_HALT;
                    else if (m_once || !run) begin m_mode = M_IDLE; m_once = 0; end
                    else m_stage = 1;
                end
            end
        end
    endtask

    // One clock of stimulus: publish what the DUT should show now, then drive inputs for the next edge.
    task automatic cyc(input bit rst, input bit run, input bit step, input bit halt,
                       input bit ready, input bit wb, input bit op);
        @(posedge Clock);
        #2;
        Reset = rst; Run = run; Step = step; Halt_Request = halt;
        Mem_Ready = ready; Mem_Access_WB = wb; Opcode_Is_NOP = op;
        if (rst) model_reset();
        exp_q.push_back(model_view());
        if (!rst) model_clock(run, step, halt, ready, wb, op);
    endtask

    obs_t mon_e, mon_a;
    always @(negedge Clock) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_a = {Stage, NOP_FLAG, Instr_Done, Running, Halted, Mem_Timeout};
            n_checks++;
            if (mon_a !== mon_e) begin
                n_fail++;
                $display("FAIL outputs @%0t: got stage=%0d nop=%b done=%b run=%b halt=%b to=%b, expected stage=%0d nop=%b done=%b run=%b halt=%b to=%b",
                         $time, mon_a.stage, mon_a.nop, mon_a.done, mon_a.running, mon_a.halted, mon_a.timeout,
                         mon_e.stage, mon_e.nop, mon_e.done, mon_e.running, mon_e.halted, mon_e.timeout);
            end
        end
    end

    task automatic check_now(input string name, input logic [7:0] got, input logic [7:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, got, want);
        end
    endtask

    initial begin
        model_reset();
        repeat (3) cyc(1, 0, 0, 0, 0, 0, 0);

        // Continuous run, memory always ready.
        repeat (22) cyc(0, 1, 0, 0, 1, 0, 0);
        repeat (7) cyc(0, 0, 0, 0, 1, 0, 0);

        // Single step, then a second step pulse mid-instruction that must be ignored.
        cyc(0, 0, 1, 0, 1, 0, 0);
        repeat (2) cyc(0, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 1, 0, 0);
        repeat (8) cyc(0, 0, 0, 0, 1, 0, 0);

        // Fetch stalls 3 cycles; stage 4 never stalls when the instruction has no memory access.
        for (int i = 0; i < 14; i++)
            cyc(0, 1, 0, 0, !(m_stage == 1 && m_wait < 3) && m_stage != 4, 0, 0);
        // NOP with memory access: stage 4 must not stall even with Mem_Ready low.
        for (int i = 0; i < 12; i++)
            cyc(0, 1, 0, 0, m_stage != 4, 1, 1);

        // Halt requested at stage 2 finishes the instruction first.
        for (int i = 0; i < 10 && m_stage != 2; i++) cyc(0, 1, 0, 0, 1, 0, 0);
        repeat (8) cyc(0, 1, 1, 1, 1, 0, 0);
        repeat (2) cyc(1, 0, 0, 0, 0, 0, 0);

        // Stuck memory in stage 4 times out.
        for (int i = 0; i < 30; i++)
            cyc(0, 1, 0, 0, m_stage != 4, 1, 0);
        repeat (2) cyc(1, 0, 0, 0, 0, 0, 0);

        // Asynchronous reset in the middle of stage 3.
        for (int i = 0; i < 10 && m_stage != 3; i++) cyc(0, 1, 0, 0, 1, 0, 0);
        @(posedge Clock);
        #2;
        check_now("stage_before_reset", {5'd0, Stage}, 8'd3);
        Reset = 1'b1;
        #1;
        check_now("async_reset_outputs",
                  {2'b0, Stage, NOP_FLAG, Instr_Done, Running}, 8'd0);
        check_now("async_reset_flags", {6'b0, Halted, Mem_Timeout}, 8'd0);
        model_reset();
        exp_q.push_back(model_view());
        repeat (2) cyc(1, 0, 0, 0, 0, 0, 0);

        // Randomized episodes, each starting from reset.
        for (int ep = 0; ep < 8; ep++) begin
            for (int i = 0; i < 80; i++)
                cyc(0, $urandom_range(0, 9) != 0, ($urandom % 8) == 0, ($urandom % 70) == 0,
                    ($urandom % 4) != 0, $urandom % 2, $urandom % 2);
            repeat (2) cyc(1, 0, 0, 0, 0, 0, 0);
        end

        repeat (3) @(negedge Clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
